// File: rtl/dtc_pulse_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : dtc_pulse_gen_if
// Brief   : Start/running/ready handshake bundle for the DTC pulse generator.
// Rev     : 1.0  initial release
// ============================================================================
interface dtc_pulse_gen_if #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
);
  logic             start;
  logic [WIDTH-1:0] count_in;
  logic [REP_W-1:0] periods_in;
  logic             abort;
  logic             data_out;
  logic             running;
  logic             ready;

  // Requester side: issues start/abort with the run parameters.
  modport master (
    output start, count_in, periods_in, abort,
    input  data_out, running, ready
  );

  // Generator side.
  modport slave (
    input  start, count_in, periods_in, abort,
    output data_out, running, ready
  );
endinterface
`default_nettype wire

// File: rtl/dtc_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module  : dtc_pulse_gen
// Brief   : Digital-to-time pulse generator. Converts an N-cycle count into a
//           single high pulse (K=0) or K periods of N-high/N-low square wave,
//           with a one-cycle ready strobe on completion.
// Rev     : 1.0  initial release
// ============================================================================
module dtc_pulse_gen #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
) (
  input  wire logic       clk,
  input  wire logic       rst,
  dtc_pulse_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state_q,    state_d;
  logic [WIDTH-1:0] n_q,        n_d;        // latched phase length N
  logic [WIDTH-1:0] phase_q,    phase_d;    // cycles left in current phase, minus one
  logic [REP_W-1:0] period_q,   period_d;   // periods left; 0 in HIGH means single-pulse mode
  logic             data_out_q, data_out_d;
  logic             running_q,  running_d;
  logic             ready_q,    ready_d;

  // Next-state and registered-output decode; outputs are computed for the
  // state being entered so every port comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    phase_d    = phase_q;
    period_d   = period_q;
    data_out_d = 1'b0;
    running_d  = 1'b0;
    ready_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          n_d      = bus.count_in;
          period_d = bus.periods_in;
          if (bus.count_in == '0) begin
            // Zero-width request completes immediately without a pulse.
            state_d = ST_DONE;
            ready_d = 1'b1;
          end else begin
            state_d    = ST_HIGH;
            phase_d    = bus.count_in - WIDTH'(1);
            data_out_d = 1'b1;
            running_d  = 1'b1;
          end
        end
      end

      ST_HIGH: begin
        if (phase_q == '0) begin
          if (period_q == '0) begin
            state_d = ST_DONE;
            ready_d = 1'b1;
          end else begin
            state_d   = ST_LOW;
            phase_d   = n_q - WIDTH'(1);
            running_d = 1'b1;
          end
        end else begin
          phase_d    = phase_q - WIDTH'(1);
          data_out_d = 1'b1;
          running_d  = 1'b1;
        end
      end

      ST_LOW: begin
        if (phase_q == '0) begin
          period_d = period_q - REP_W'(1);
          if (period_q == REP_W'(1)) begin
            state_d = ST_DONE;
            ready_d = 1'b1;
          end else begin
            state_d    = ST_HIGH;
            phase_d    = n_q - WIDTH'(1);
            data_out_d = 1'b1;
            running_d  = 1'b1;
          end
        end else begin
          phase_d   = phase_q - WIDTH'(1);
          running_d = 1'b1;
        end
      end

      ST_DONE: begin
        // Start is deliberately ignored here, enforcing the DONE+IDLE gap.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort cancels any active run outright; in IDLE it has nothing to cancel.
    if (bus.abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      phase_d    = '0;
      period_d   = '0;
      data_out_d = 1'b0;
      running_d  = 1'b0;
      ready_d    = 1'b0;
    end
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      phase_q    <= '0;
      period_q   <= '0;
      data_out_q <= 1'b0;
      running_q  <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      phase_q    <= phase_d;
      period_q   <= period_d;
      data_out_q <= data_out_d;
      running_q  <= running_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.running  = running_q;
  assign bus.ready    = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_dtc_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_dtc_pulse_gen
// Brief   : Scoreboard bench for dtc_pulse_gen. Each accepted start pushes the
//           expected per-cycle {data_out,running,ready} waveform; a monitor
//           pops one entry per cycle (idle zeros when empty) and compares.
// Rev     : 1.0  initial release
// ============================================================================
module tb_dtc_pulse_gen;

  logic clk = 1'b0;
  logic rst;

  dtc_pulse_gen_if #(.WIDTH(8), .REP_W(4)) bus ();

  dtc_pulse_gen #(.WIDTH(8), .REP_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [2:0] exp_q[$];
  logic [2:0] mon_exp;
  logic [2:0] mon_act;
  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;

  // Reference waveform of one run: K periods (or one pulse) of N high / N low.
  task automatic push_run(input int n, input int k);
    int reps;
    if (n != 0) begin
      reps = (k == 0) ? 1 : k;
      for (int p = 0; p < reps; p++) begin
        for (int i = 0; i < n; i++) exp_q.push_back(3'b110);
        if (k != 0)
          for (int i = 0; i < n; i++) exp_q.push_back(3'b010);
      end
    end
    exp_q.push_back(3'b001);
  endtask

  function automatic int run_len(input int n, input int k);
    if (n == 0)      return 1;
    else if (k == 0) return n + 1;
    else             return 2 * n * k + 1;
  endfunction

  // Monitor: one comparison per cycle, 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (exp_q.size() > 0) mon_exp = exp_q.pop_front();
    else                  mon_exp = 3'b000;
    mon_act = {bus.data_out, bus.running, bus.ready};
    n_checks++;
    if (mon_act === mon_exp) n_pass++;
    else $display("FAIL out_cycle %0d {data_out,running,ready} got %b expected %b",
                  cyc, mon_act, mon_exp);
  end

  // One run: start sampled at the next edge; optionally garbles ignored inputs
  // during the run and optionally aborts at a random point.
  task automatic do_run(input int n, input int k, input bit garble,
                        input bit allow_abort, input bit no_wait);
    int len;
    int ab_at;
    if (!no_wait) @(negedge clk);
    bus.start      = 1'b1;
    bus.count_in   = 8'(n);
    bus.periods_in = 4'(k);
    bus.abort      = garble ? 1'($urandom_range(0, 1)) : 1'b0;
    @(posedge clk);
    push_run(n, k);
    len   = run_len(n, k);
    ab_at = -1;
    if (allow_abort && len >= 2 && $urandom_range(0, 3) == 0)
      ab_at = int'($urandom_range(0, len - 2));
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      bus.abort = 1'b0;
      if (garble) begin
        bus.start      = 1'($urandom_range(0, 1));
        bus.count_in   = 8'($urandom);
        bus.periods_in = 4'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      if (j == ab_at) begin
        bus.abort = 1'b1;
        exp_q.delete();
        break;
      end
    end
  endtask

  // Watchdog: the stimulus uses only fixed cycle counts, this is a backstop.
  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    int r;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.count_in   = '0;
    bus.periods_in = '0;
    bus.abort      = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    do_run(5, 0, 1'b0, 1'b0, 1'b0);
    do_run(10, 2, 1'b0, 1'b0, 1'b0);
    do_run(0, 3, 1'b0, 1'b0, 1'b0);

    // Reset mid-pulse (N=20): outputs clear and no ready follows.
    @(negedge clk);
    bus.start = 1'b1; bus.count_in = 8'd20; bus.periods_in = 4'd0;
    @(posedge clk);
    push_run(20, 0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Maximum N with start held and count_in changed mid-run.
    @(negedge clk);
    bus.start = 1'b1; bus.count_in = 8'd255; bus.periods_in = 4'd0;
    @(posedge clk);
    push_run(255, 0);
    exp_q.push_back(3'b000);
    push_run(7, 0);
    for (int i = 1; i <= 257; i++) begin
      @(negedge clk);
      if (i == 100) bus.count_in = 8'd7;
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);

    // Abort on the 30th HIGH cycle, then a start on the very next edge.
    @(negedge clk);
    bus.start = 1'b1; bus.count_in = 8'd50; bus.periods_in = 4'd1;
    @(posedge clk);
    push_run(50, 1);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (29) @(negedge clk);
    bus.abort = 1'b1;
    exp_q.delete();
    @(negedge clk);
    bus.abort = 1'b0;
    do_run(4, 1, 1'b0, 1'b0, 1'b1);

    // Counter boundaries.
    do_run(1, 0, 1'b1, 1'b0, 1'b0);
    do_run(1, 15, 1'b1, 1'b0, 1'b0);
    do_run(255, 15, 1'b0, 1'b0, 1'b0);

    // Randomized runs with ignored-input garbage and random aborts.
    for (int t = 0; t < 40; t++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        n = 0; k = int'($urandom_range(0, 15));
      end else if (r == 9) begin
        n = int'($urandom_range(13, 60)); k = int'($urandom_range(0, 2));
      end else begin
        n = int'($urandom_range(1, 12)); k = int'($urandom_range(0, 15));
      end
      do_run(n, k, 1'b1, 1'b1, 1'b0);
    end

    // Drain and confirm every expected cycle was observed.
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain leftover %0d expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
